micro_seq_v: RTL and testbench

- Micro-op sequencer that sits in front of the micro-op class decoder.
- Accepts 4-bit micro-op codes through a valid/ready interface and buffers them in a small FIFO.
- Issues one micro-op at a time: drives the decoder's enable and code, pulses a per-class issue strobe to the ALU, load/store or branch unit, then waits for that unit's done.
- A completed branch flushes all buffered micro-ops.

---
 rtl/micro_seq_v.sv | 153 +++++++++++++++
 tb/tb_micro_seq_v.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/micro_seq_v.sv
// rtl/micro_seq_v.sv - micro-op sequencer: FIFO-buffered issue to ALU/LS/branch units, flush on branch.
// Optional done watchdog enabled by defining MICRO_SEQ_TIMEOUT_EN.
module micro_seq_v #(
  parameter int DEPTH        = 4,
  parameter int DONE_TIMEOUT = 15
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_code_valid,
  input  logic [3:0]             i_code,
  output logic                   o_code_ready,
  output logic                   o_dec_en,
  output logic [3:0]             o_dec_code,
  output logic                   o_issue_a,
  output logic                   o_issue_l,
  output logic                   o_issue_b,
  input  logic                   i_done,
  output logic                   o_busy,
  output logic [$clog2(DEPTH):0] o_count,
  output logic                   o_flush,
  output logic                   o_timeout_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_FLUSH} state_t;
  typedef enum logic [1:0] {C_NOP, C_A, C_L, C_B} cls_t;

  function automatic cls_t classify(input logic [3:0] c);
    case (c)
      4'b1010, 4'b1011, 4'b1100:          classify = C_A;
      4'b0010, 4'b0011, 4'b0100, 4'b1110: classify = C_L;
      4'b1111:                            classify = C_B;
      default:                            classify = C_NOP;
    endcase
  endfunction

  state_t        state;
  logic [3:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push;
  logic          pop;
  logic [3:0]    head;
  cls_t          head_cls;

  // Ready is gated by reset so nothing is offered while the block is held.
  assign o_code_ready = i_rst_n && (o_count < CW'(DEPTH)) && (state != S_FLUSH);
  assign push         = i_code_valid && o_code_ready;
  assign pop          = (state == S_IDLE) && (o_count != '0);
  assign head         = mem[rd_ptr];
  assign head_cls     = classify(head);

  always_ff @(posedge i_clk) begin
    if (push) mem[wr_ptr] <= i_code;
  end

`ifdef MICRO_SEQ_TIMEOUT_EN
  localparam int TW = $clog2(DONE_TIMEOUT + 1);
  logic [TW-1:0] tmo_cnt;
`else
  assign o_timeout_err = 1'b0;
`endif

  // o_dec_code doubles as the current-op register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= S_IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      o_count    <= '0;
      o_dec_en   <= 1'b0;
      o_dec_code <= 4'b0000;
      o_issue_a  <= 1'b0;
      o_issue_l  <= 1'b0;
      o_issue_b  <= 1'b0;
      o_busy     <= 1'b0;
      o_flush    <= 1'b0;
`ifdef MICRO_SEQ_TIMEOUT_EN
      tmo_cnt       <= '0;
      o_timeout_err <= 1'b0;
`endif
    end else begin
      o_issue_a <= 1'b0;
      o_issue_l <= 1'b0;
      o_issue_b <= 1'b0;
      o_flush   <= 1'b0;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      o_count <= o_count + 1'b1;
      else if (pop && !push) o_count <= o_count - 1'b1;

      case (state)
        S_IDLE: begin
          if (pop) begin
            state      <= S_ISSUE;
            o_dec_code <= head;
            o_dec_en   <= 1'b1;
            o_busy     <= 1'b1;
            o_issue_a  <= (head_cls == C_A);
            o_issue_l  <= (head_cls == C_L);
            o_issue_b  <= (head_cls == C_B);
          end
        end
        S_ISSUE: begin
          if (classify(o_dec_code) == C_NOP) begin
            state    <= S_IDLE;
            o_dec_en <= 1'b0;
            o_busy   <= 1'b0;
          end else begin
            state <= S_WAIT;
`ifdef MICRO_SEQ_TIMEOUT_EN
            tmo_cnt <= '0;
`endif
          end
        end
        S_WAIT: begin
          if (i_done) begin
            o_dec_en <= 1'b0;
            if (classify(o_dec_code) == C_B) begin
              state   <= S_FLUSH;
              o_flush <= 1'b1;
            end else begin
              state  <= S_IDLE;
              o_busy <= 1'b0;
            end
          end
`ifdef MICRO_SEQ_TIMEOUT_EN
          else if (tmo_cnt == TW'(DONE_TIMEOUT - 1)) begin
            // Abandon the op without flushing, even for a branch.
            state         <= S_IDLE;
            o_dec_en      <= 1'b0;
            o_busy        <= 1'b0;
            o_timeout_err <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
`endif
        end
        S_FLUSH: begin
          // Ready is low here, so no push can collide with the discard.
          state   <= S_IDLE;
          o_busy  <= 1'b0;
          rd_ptr  <= wr_ptr;
          o_count <= '0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_micro_seq_v.sv
// tb/tb_micro_seq_v.sv - self-checking bench for micro_seq_v (honours MICRO_SEQ_TIMEOUT_EN).
module tb_micro_seq_v;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       code_valid;
  logic [3:0] code;
  logic       code_ready;
  logic       dec_en;
  logic [3:0] dec_code;
  logic       issue_a, issue_l, issue_b;
  logic       done;
  logic       busy;
  logic [2:0] count;
  logic       flush;
  logic       timeout_err;

  int n_chk  = 0;
  int n_fail = 0;

  micro_seq_v #(.DEPTH(DEPTH), .DONE_TIMEOUT(15)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_code_valid (code_valid),
    .i_code       (code),
    .o_code_ready (code_ready),
    .o_dec_en     (dec_en),
    .o_dec_code   (dec_code),
    .o_issue_a    (issue_a),
    .o_issue_l    (issue_l),
    .o_issue_b    (issue_b),
    .i_done       (done),
    .o_busy       (busy),
    .o_count      (count),
    .o_flush      (flush),
    .o_timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] code;
    logic       a;
    logic       l;
    logic       b;
  } vec_t;

  vec_t tbl[16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; code_valid = 1'b0; code = 4'h0; done = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
  endtask

  // 0 = NOP, 1 = ALU, 2 = load/store, 3 = branch
  function automatic int cls_of(input logic [3:0] c);
    if (c inside {4'hA, 4'hB, 4'hC}) return 1;
    if (c inside {4'h2, 4'h3, 4'h4, 4'hE}) return 2;
    if (c == 4'hF) return 3;
    return 0;
  endfunction

  initial begin
    int acc, nl, na, n_str;
    logic [3:0] q[$];
    logic [3:0] exp_code;
    logic       prev_en, rose, waiting, arm, cur_b, flush_pending, in_flush;
    int         dly, ecls;

    tbl[0]  = '{4'h0, 0, 0, 0}; tbl[1]  = '{4'h1, 0, 0, 0};
    tbl[2]  = '{4'h2, 0, 1, 0}; tbl[3]  = '{4'h3, 0, 1, 0};
    tbl[4]  = '{4'h4, 0, 1, 0}; tbl[5]  = '{4'h5, 0, 0, 0};
    tbl[6]  = '{4'h6, 0, 0, 0}; tbl[7]  = '{4'h7, 0, 0, 0};
    tbl[8]  = '{4'h8, 0, 0, 0}; tbl[9]  = '{4'h9, 0, 0, 0};
    tbl[10] = '{4'hA, 1, 0, 0}; tbl[11] = '{4'hB, 1, 0, 0};
    tbl[12] = '{4'hC, 1, 0, 0}; tbl[13] = '{4'hD, 0, 0, 0};
    tbl[14] = '{4'hE, 0, 1, 0}; tbl[15] = '{4'hF, 0, 0, 1};

    rst_n = 1'b0; code_valid = 1'b0; code = 4'h0; done = 1'b0;
    tick();
    chk("rst_ready", code_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_count", count, 0);
    chk("rst_dec_en", dec_en, 0);
    chk("rst_dec_code", dec_code, 0);
    chk("rst_issue", {issue_a, issue_l, issue_b}, 0);
    chk("rst_flush", flush, 0);
    chk("rst_err", timeout_err, 0);
    do_reset();
    chk("idle_ready", code_ready, 1);

    // Class decode and issue latency for every code
    for (int i = 0; i < 16; i++) begin
      code_valid = 1'b1; code = tbl[i].code;
      tick();
      code_valid = 1'b0;
      chk("tbl_e0_issue", {issue_a, issue_l, issue_b}, 0);
      chk("tbl_e0_count", count, 1);
      tick();
      chk("tbl_issue", {issue_a, issue_l, issue_b}, {tbl[i].a, tbl[i].l, tbl[i].b});
      chk("tbl_dec_en", dec_en, 1);
      chk("tbl_dec_code", dec_code, tbl[i].code);
      chk("tbl_count", count, 0);
      if (!(tbl[i].a || tbl[i].l || tbl[i].b)) begin
        tick();
        chk("tbl_nop_busy", busy, 0);
      end else begin
        tick();
        chk("tbl_wait_issue", {issue_a, issue_l, issue_b}, 0);
        chk("tbl_wait_en", dec_en, 1);
        chk("tbl_wait_busy", busy, 1);
        tick(); tick();
        done = 1'b1;
        tick();
        done = 1'b0;
        if (tbl[i].b) begin
          chk("tbl_b_flush", flush, 1);
          tick();
        end
        chk("tbl_done_busy", busy, 0);
        chk("tbl_done_en", dec_en, 0);
        chk("tbl_done_code", dec_code, tbl[i].code);
      end
    end

    // Back-to-back NOPs
    do_reset();
    n_str = 0;
    for (int i = 0; i < 8; i++) begin
      code_valid = (i < 3);
      code = (i == 0) ? 4'h0 : (i == 1) ? 4'h6 : 4'h1;
      tick();
      if (issue_a || issue_l || issue_b) n_str++;
      if (i == 5) chk("nop_count6", count, 0);
    end
    code_valid = 1'b0;
    chk("nop_strobes", n_str, 0);
    chk("nop_busy", busy, 0);

    // Full FIFO behind a stalled load
    do_reset();
    acc = 0;
    code = 4'h3;
    for (int i = 0; i < 10; i++) begin
      code_valid = (acc < DEPTH + 1);
      if (code_valid && code_ready) acc++;
      tick();
    end
    code_valid = 1'b0;
    chk("full_acc", acc, DEPTH + 1);
    chk("full_count", count, DEPTH);
    chk("full_ready", code_ready, 0);
    chk("full_en", dec_en, 1);
    done = 1'b1;
    tick();
    chk("full_ready_idle", code_ready, 0);
    tick();
    chk("full_ready_back", code_ready, 1);
    nl = 0;
    for (int i = 0; i < 20; i++) begin
      if (issue_l) begin
        nl++;
        chk("full_code", dec_code, 4'h3);
      end
      if (issue_a || issue_b) nl = 100;
      tick();
    end
    done = 1'b0;
    chk("full_nl", nl, DEPTH);
    chk("full_empty", count, 0);

    // Branch flush discards queued ops and refuses a push during FLUSH
    do_reset();
    code_valid = 1'b1; code = 4'hF; tick();
    code = 4'hA; tick();
    chk("br_issue_b", issue_b, 1);
    code = 4'hE; tick();
    code_valid = 1'b0; tick();
    chk("br_count", count, 2);
    done = 1'b1; tick();
    done = 1'b0;
    code_valid = 1'b1; code = 4'hA;
    chk("br_flush", flush, 1);
    chk("br_ready", code_ready, 0);
    chk("br_en", dec_en, 0);
    tick();
    code_valid = 1'b0;
    chk("br_flush_end", flush, 0);
    chk("br_count0", count, 0);
    na = 0;
    for (int i = 0; i < 10; i++) begin
      if (issue_a || issue_l) na++;
      tick();
    end
    chk("br_no_issue", na, 0);
    chk("br_count_hold", count, 0);

    // Asynchronous reset mid-WAIT
    do_reset();
    code_valid = 1'b1; code = 4'hA; tick();
    code_valid = 1'b0; tick(); tick();
    chk("ar_wait", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_busy", busy, 0);
    chk("ar_en", dec_en, 0);
    chk("ar_code", dec_code, 0);
    chk("ar_ready", code_ready, 0);
    tick();
    rst_n = 1'b1; done = 1'b1;
    tick();
    done = 1'b0;
    tick();
    chk("ar_after_busy", busy, 0);
    chk("ar_after_issue", {issue_a, issue_l, issue_b, flush}, 0);

    // Done watchdog
    do_reset();
    code_valid = 1'b1; code = 4'hC; tick();
    code = 4'hA; tick();
    code_valid = 1'b0;
    chk("to_issue", issue_a, 1);
    repeat (15) tick();
    chk("to_pre_err", timeout_err, 0);
    chk("to_pre_en", dec_en, 1);
    tick();
`ifdef MICRO_SEQ_TIMEOUT_EN
    chk("to_err", timeout_err, 1);
    chk("to_idle", busy, 0);
    tick();
    chk("to_next_issue", issue_a, 1);
    chk("to_next_code", dec_code, 4'hA);
    chk("to_sticky", timeout_err, 1);
`else
    chk("to_err", timeout_err, 0);
    chk("to_wait", busy, 1);
    tick();
    chk("to_no_issue", issue_a, 0);
    chk("to_held_code", dec_code, 4'hC);
`endif

    // Randomized traffic against a queue model
    do_reset();
    q.delete();
    prev_en = 0; waiting = 0; arm = 0; cur_b = 0; flush_pending = 0; dly = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      rose = dec_en && !prev_en;
      prev_en = dec_en;
      ecls = 0;
      if (rose) begin
        if (q.size() == 0) begin
          chk("rnd_pop_empty", 1, 0);
        end else begin
          exp_code = q.pop_front();
          ecls = cls_of(exp_code);
          chk("rnd_dec_code", dec_code, exp_code);
          if (ecls != 0) begin
            arm = 1;
            cur_b = (ecls == 3);
          end
        end
      end
      chk("rnd_strobes", {issue_a, issue_l, issue_b},
          {rose && ecls == 1, rose && ecls == 2, rose && ecls == 3});
      chk("rnd_count", count, q.size());
      in_flush = flush_pending;
      chk("rnd_flush", flush, in_flush);
      if (in_flush) begin
        q.delete();
        flush_pending = 0;
      end
      chk("rnd_ready", code_ready, !in_flush && q.size() < DEPTH);

      if (waiting) begin
        if (dly == 0) begin
          done = 1'b1;
          waiting = 0;
          flush_pending = cur_b;
        end else begin
          done = 1'b0;
          dly--;
        end
      end else begin
        done = ($urandom % 4 == 0);
      end
      if (arm) begin
        arm = 0;
        waiting = 1;
        dly = $urandom % 4;
      end
      code_valid = $urandom % 2;
      code = 4'($urandom);
      if (code_valid && code_ready) q.push_back(code);
      tick();
    end
    code_valid = 1'b0; done = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
